// File: rtl/ram_dp_be.sv
// ram_dp_be - dual-port word RAM with byte enables and a built-in clear engine.
//
// Port A is a read/write port with per-byte write enables. Port B is an
// independent read-only port. After reset, or whenever clear_req is pulsed
// while idle, the clear engine walks the whole array writing zeros, one word
// per cycle. While it runs, ready is low and all accesses are ignored.
//
// Parameters:
//   DATA_WIDTH    word width in bits (multiple of 8)
//   ADDRESS_WIDTH address bits on both ports
//   DEPTH         number of words (<= 2**ADDRESS_WIDTH)
//   READ_LATENCY  1 or 2 cycles from accepted access to data/valid
//   WRITE_MODE    port A write-cycle output: 0 no change, 1 write-first,
//                 2 read-first
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   clear_req  request a re-zero of the array (taken only when idle)
//   ready      array usable; low while clearing
//   a_wEn      port A write enable (0 = read)
//   a_en       port A access strobe
//   a_be       port A byte enables, bit i covers bits [8i+7:8i]
//   a_addr     port A address
//   a_dataIn   port A write data
//   a_dataOut  port A read data (holds when a_valid is low)
//   a_valid    port A data valid pulse
//   b_en       port B read strobe
//   b_addr     port B address
//   b_dataOut  port B read data (holds when b_valid is low)
//   b_valid    port B data valid pulse

module ram_dp_be #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 4096,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_MODE    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_req,
    output logic                      ready,
    input  logic                      a_wEn,
    input  logic                      a_en,
    input  logic [DATA_WIDTH/8-1:0]   a_be,
    input  logic [ADDRESS_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0]     a_dataIn,
    output logic [DATA_WIDTH-1:0]     a_dataOut,
    output logic                      a_valid,
    input  logic                      b_en,
    input  logic [ADDRESS_WIDTH-1:0]  b_addr,
    output logic [DATA_WIDTH-1:0]     b_dataOut,
    output logic                      b_valid
);

    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                   state;
    state_t                   stateNext;
    logic [INDEX_WIDTH-1:0]   clearPtr;
    logic [INDEX_WIDTH-1:0]   clearPtrNext;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     aWrite;
    logic                     aRead;
    logic                     bRead;
    logic                     aInRange;
    logic                     bInRange;
    logic [INDEX_WIDTH-1:0]   aIndex;
    logic [INDEX_WIDTH-1:0]   bIndex;
    logic [DATA_WIDTH-1:0]    aOldWord;
    logic [DATA_WIDTH-1:0]    bWord;
    logic [DATA_WIDTH-1:0]    aMergedWord;
    logic [DATA_WIDTH-1:0]    aResultWord;
    logic                     aResultValid;

    logic                     aValid1;
    logic                     bValid1;
    logic [DATA_WIDTH-1:0]    aData1;
    logic [DATA_WIDTH-1:0]    bData1;

    // The array is usable exactly when the clear engine is parked in IDLE.
    assign ready = (state == IDLE);

    assign aWrite = ready && a_en && a_wEn;
    assign aRead  = ready && a_en && !a_wEn;
    assign bRead  = ready && b_en;

    // Addresses at or beyond DEPTH have no storage: reads see zero,
    // writes are dropped.
    assign aInRange = ({1'b0, a_addr} < DEPTH_LIMIT);
    assign bInRange = ({1'b0, b_addr} < DEPTH_LIMIT);
    assign aIndex   = a_addr[INDEX_WIDTH-1:0];
    assign bIndex   = b_addr[INDEX_WIDTH-1:0];
    assign aOldWord = aInRange ? mem[aIndex] : '0;
    assign bWord    = bInRange ? mem[bIndex] : '0;

    // Clear engine state register; reset restarts the walk from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clearPtr <= '0;
        end else begin
            state    <= stateNext;
            clearPtr <= clearPtrNext;
        end
    end

    // Clear engine next state: one word per cycle until the last word has
    // been written, then idle until the next clear request.
    always_comb begin
        stateNext    = state;
        clearPtrNext = clearPtr;
        case (state)
            CLEAR: begin
                clearPtrNext = clearPtr + 1'b1;
                if (clearPtr == LAST_INDEX) begin
                    stateNext    = IDLE;
                    clearPtrNext = '0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    stateNext    = CLEAR;
                    clearPtrNext = '0;
                end
            end
            default: begin
                stateNext    = CLEAR;
                clearPtrNext = '0;
            end
        endcase
    end

    // Word as it will look after a port A write, used for write-first output.
    always_comb begin
        aMergedWord = aOldWord;
        for (int i = 0; i < BYTES; i++) begin
            if (a_be[i]) begin
                aMergedWord[8*i +: 8] = a_dataIn[8*i +: 8];
            end
        end
    end

    // Array storage. The clear engine owns the write port while clearing;
    // otherwise port A writes only the enabled bytes. Reads elsewhere sample
    // the array before this edge's update, which gives port B read-first
    // behaviour on collisions.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clearPtr] <= '0;
        end else if (aWrite && aInRange) begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_be[i]) begin
                    mem[aIndex][8*i +: 8] <= a_dataIn[8*i +: 8];
                end
            end
        end
    end

    // Port A result selection: reads always produce data; writes produce
    // data only in write-first or read-first mode.
    always_comb begin
        aResultValid = 1'b0;
        aResultWord  = aOldWord;
        if (aRead) begin
            aResultValid = 1'b1;
        end else if (aWrite) begin
            case (WRITE_MODE)
                1: begin
                    aResultValid = 1'b1;
                    aResultWord  = aMergedWord;
                end
                2: begin
                    aResultValid = 1'b1;
                end
                default: begin
                    aResultValid = 1'b0;
                end
            endcase
        end
    end

    // First output stage: valid pulses follow each accepted access, data
    // registers only load when there is something new to show.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aValid1 <= 1'b0;
            aData1  <= '0;
            bValid1 <= 1'b0;
            bData1  <= '0;
        end else begin
            aValid1 <= aResultValid;
            bValid1 <= bRead;
            if (aResultValid) begin
                aData1 <= aResultWord;
            end
            if (bRead) begin
                bData1 <= bWord;
            end
        end
    end

    if (READ_LATENCY == 2) begin : gen_latency2
        logic                  aValid2;
        logic                  bValid2;
        logic [DATA_WIDTH-1:0] aData2;
        logic [DATA_WIDTH-1:0] bData2;

        // Optional second output stage; data still holds between valids.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                aValid2 <= 1'b0;
                aData2  <= '0;
                bValid2 <= 1'b0;
                bData2  <= '0;
            end else begin
                aValid2 <= aValid1;
                bValid2 <= bValid1;
                if (aValid1) begin
                    aData2 <= aData1;
                end
                if (bValid1) begin
                    bData2 <= bData1;
                end
            end
        end

        assign a_valid   = aValid2;
        assign a_dataOut = aData2;
        assign b_valid   = bValid2;
        assign b_dataOut = bData2;
    end else begin : gen_latency1
        assign a_valid   = aValid1;
        assign a_dataOut = aData1;
        assign b_valid   = bValid1;
        assign b_dataOut = bData1;
    end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised successor to the single-port instruction/data RAM.
- One read/write port (A) with byte enables, plus an independent read-only port (B).
- Configurable read latency and read-during-write mode.
- Built-in clear engine zeroes the whole array after reset or on request; `ready` gates all accesses.
- Used as shared IRAM/DMEM: port A serves CPU load/store, port B serves instruction fetch or debug readback.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 12, address bits on both ports.
- DEPTH, 4096, number of words; DEPTH <= 2**ADDRESS_WIDTH.
- READ_LATENCY, 1, 1 or 2 cycles from accepted read to data/valid; 2 adds an output register stage.
- WRITE_MODE, 0, port A output on a write cycle: 0 = NO_CHANGE (hold), 1 = WRITE_FIRST (merged new word), 2 = READ_FIRST (old word).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  pulse in IDLE to re-zero the array
- ready  out  1  1 = array usable; 0 while clearing
- a_wEn  in  1  port A write enable; 0 = read
- a_en  in  1  port A access strobe
- a_be  in  DATA_WIDTH/8  port A byte enables, bit i -> bits [8i+7:8i]
- a_addr  in  ADDRESS_WIDTH  port A address
- a_dataIn  in  DATA_WIDTH  port A write data
- a_dataOut  out  DATA_WIDTH  port A read data
- a_valid  out  1  port A data valid pulse
- b_en  in  1  port B read strobe
- b_addr  in  ADDRESS_WIDTH  port B address
- b_dataOut  out  DATA_WIDTH  port B read data
- b_valid  out  1  port B data valid pulse

Behaviour:
- Reset (async, high): all outputs go to 0 immediately, including ready, a_dataOut, b_dataOut, a_valid, b_valid and pipeline registers. FSM enters CLEAR with clear pointer = 0. Array contents are not asynchronously reset.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to word[ptr], then ptr++. After the cycle writing DEPTH-1, go to IDLE; ready=1 from the next cycle. Clear takes exactly DEPTH cycles.
  - IDLE: clear_req=1 -> CLEAR next cycle, ptr=0, ready=0.
  - clear_req while in CLEAR is ignored.
  - reset asserted mid-clear restarts from ptr=0.
- Accesses are accepted only when ready=1. With ready=0, a_en/b_en are ignored: no write, no valid.
- Port A write (a_en & a_wEn & ready): for each i with a_be[i]=1, byte i of word[a_addr] <= byte i of a_dataIn; bytes with a_be[i]=0 are unchanged. a_be=0 is a legal no-op write.
- Port A write-cycle output, per WRITE_MODE:
  - 0: a_dataOut holds and a_valid stays 0.
  - 1: a_dataOut = merged new word; a_valid pulses.
  - 2: a_dataOut = word before the write; a_valid pulses.
- Port A read (a_en & !a_wEn & ready): a_dataOut = word[a_addr] and a_valid=1 after READ_LATENCY edges.
- Port B read (b_en & ready): b_dataOut = word[b_addr] and b_valid=1 after READ_LATENCY edges.
- a_valid/b_valid are single-cycle pulses per accepted access. Back-to-back accesses give back-to-back valids, with full throughput of 1 access/cycle/port.
- Data outputs hold their last value when valid=0.
- Collision (port A write and port B read to the same address in the same cycle): B returns the old word (read-first), independent of WRITE_MODE.
- Addresses >= DEPTH: writes dropped, reads return 0 with valid asserted.
- Reads in flight when clear_req is taken still complete with pre-clear data.

Test Plan:
- DEPTH=16, READ_LATENCY=1. Release reset; ready stays 0 for 16 cycles then 1. A read of addr 5 on port A and on port B returns 0x00000000 with a_valid=1 and b_valid=1 one cycle later.
- Write addr 3 = 0xDEADBEEF with a_be=4'b1111, then write a_be=4'b0101 with 0x11223344. A read of addr 3 returns 0xDE22BE44.
- WRITE_MODE=0/1/2, word[7]=0xAAAAAAAA, write 0x55555555 to addr 7. Mode 0: a_dataOut holds its prior value, a_valid=0. Mode 1: 0x55555555, a_valid=1. Mode 2: 0xAAAAAAAA, a_valid=1.
- Same cycle: port A writes 0x12345678 to addr 2, port B reads addr 2 (old value 0). b_dataOut=0; a port B read on the next cycle returns 0x12345678.
- READ_LATENCY=2, port B reads addr 0,1,2 on consecutive cycles. b_valid is high on cycles 2,3,4 with the matching words; port A is issued concurrently and is unaffected.
- Fill addr 9 = 0xCAFEF00D, pulse clear_req, assert reset mid-clear at ptr=6, accesses issued during clear. ready returns 16 cycles after reset release; accesses during clear produce no valid; addr 9 reads 0.
